// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default widths for the pipeline sequencer.
// Holds the FSM state encoding and the per-stage valid-bit bundle.
package pipe_ctrl_pkg;

    localparam int PC_REG_AW = 5;
    localparam int PC_CNT_W  = 32;

    typedef enum logic [1:0] {
        PC_RUN    = 2'd0,
        PC_LSWAIT = 2'd1,
        PC_HALT   = 2'd2
    } pc_state_t;

    typedef struct packed {
        logic id;
        logic ex;
        logic mem;
        logic wb;
    } stage_vld_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detect: EX load writing a register the ID instruction reads.
// Latency: purely combinational. Backpressure: none, it only raises lu.
module pipe_ctrl_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              vld_id,
    input  logic              vld_ex,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_en,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    output logic              lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_en && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_en && (id_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign lu = vld_ex && ex_is_load && (ex_rd != '0) && vld_id && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage valids, hold enables, halt FSM and perf counters.
// Latency: hold/pc enables are same-cycle combinational; valids/halted/counters registered.
// Backpressure: an LSU wait freezes IF..MEM with zero latency while WB drains bubbles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = PC_REG_AW,
    parameter int CNT_W  = PC_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_inst_vld,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_en,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic              mem_ls_req,
    input  logic              mem_ls_ready,
    input  logic              wb_ebreak,
    output logic              pc_en,
    output logic              pc_sel_redir,
    output logic              hold_id,
    output logic              hold_ex,
    output logic              hold_mem,
    output logic              hold_wb,
    output logic              vld_id,
    output logic              vld_ex,
    output logic              vld_mem,
    output logic              vld_wb,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pc_state_t  state;
    pc_state_t  state_nxt;
    stage_vld_t vld;
    stage_vld_t vld_nxt;
    logic       halt_mode;
    logic       lu;
    logic       mw;
    logic       rd;
    logic       flush_inc;
    logic       stall_inc;

    pipe_ctrl_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .vld_id     (vld.id),
        .vld_ex     (vld.ex),
        .id_rs1     (id_rs1),
        .id_rs1_en  (id_rs1_en),
        .id_rs2     (id_rs2),
        .id_rs2_en  (id_rs2_en),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .lu         (lu)
    );

    assign halt_mode = (state == PC_HALT);
    assign mw        = vld.mem && mem_ls_req && !mem_ls_ready;
    assign rd        = vld.ex && ex_redirect;

    always_comb begin
        state_nxt    = state;
        vld_nxt      = vld;
        pc_en        = 1'b1;
        pc_sel_redir = 1'b0;
        hold_id      = 1'b0;
        hold_ex      = 1'b0;
        hold_mem     = 1'b0;
        flush_inc    = 1'b0;

        // Priority ladder; a redirect or load-use under an LSU wait is re-evaluated once EX moves
        if (halt_mode) begin
            pc_en    = 1'b0;
            hold_id  = 1'b1;
            hold_ex  = 1'b1;
            hold_mem = 1'b1;
            vld_nxt.wb = 1'b0;
        end else if (mw) begin
            pc_en    = 1'b0;
            hold_id  = 1'b1;
            hold_ex  = 1'b1;
            hold_mem = 1'b1;
            vld_nxt.wb = 1'b0;
        end else if (rd) begin
            pc_sel_redir = 1'b1;
            flush_inc    = 1'b1;
            vld_nxt      = '{id: 1'b0, ex: 1'b0, mem: 1'b1, wb: vld.mem};
        end else if (lu) begin
            pc_en   = 1'b0;
            hold_id = 1'b1;
            vld_nxt = '{id: vld.id, ex: 1'b0, mem: vld.ex, wb: vld.mem};
        end else begin
            vld_nxt = '{id: if_inst_vld, ex: vld.id, mem: vld.ex, wb: vld.mem};
        end

        if (vld.wb && wb_ebreak) begin
            state_nxt = PC_HALT;
        end else begin
            case (state)
                PC_RUN:    if (mw) state_nxt = PC_LSWAIT;
                PC_LSWAIT: if (mem_ls_ready) state_nxt = PC_RUN;
                default:   state_nxt = state;
            endcase
        end
    end

    assign stall_inc = !pc_en && !halt_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PC_RUN;
            vld       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            vld   <= vld_nxt;
            if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hold_wb = 1'b0;
    assign vld_id  = vld.id;
    assign vld_ex  = vld.ex;
    assign vld_mem = vld.mem;
    assign vld_wb  = vld.wb;
    assign halted  = halt_mode;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a queue-level pipeline model checked every cycle.
module tb_pipe_ctrl;

    localparam int AW = 5;
    localparam int CW = 32;
    localparam int M_HALT = 0, M_MW = 1, M_RD = 2, M_LU = 3, M_NORM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_inst_vld;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_rs1_en, id_rs2_en, ex_is_load, ex_redirect;
    logic          mem_ls_req, mem_ls_ready, wb_ebreak;
    logic          pc_en, pc_sel_redir, hold_id, hold_ex, hold_mem, hold_wb;
    logic          vld_id, vld_ex, vld_mem, vld_wb, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    // model: bit0=ID, bit1=EX, bit2=MEM, bit3=WB
    logic [3:0]    m_vld;
    logic          m_halt;
    logic [CW-1:0] m_stall, m_flush;

    pipe_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .if_inst_vld(if_inst_vld),
        .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
        .mem_ls_req(mem_ls_req), .mem_ls_ready(mem_ls_ready), .wb_ebreak(wb_ebreak),
        .pc_en(pc_en), .pc_sel_redir(pc_sel_redir),
        .hold_id(hold_id), .hold_ex(hold_ex), .hold_mem(hold_mem), .hold_wb(hold_wb),
        .vld_id(vld_id), .vld_ex(vld_ex), .vld_mem(vld_mem), .vld_wb(vld_wb),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int model_mode();
        logic dep;
        dep = (id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd);
        if (m_halt) return M_HALT;
        if (m_vld[2] && mem_ls_req && !mem_ls_ready) return M_MW;
        if (m_vld[1] && ex_redirect) return M_RD;
        if (m_vld[1] && ex_is_load && ex_rd != 0 && m_vld[0] && dep) return M_LU;
        return M_NORM;
    endfunction

    always @(posedge clk) begin
        int md;
        logic [3:0] nv;
        logic ebk;
        if (!rst_n) begin
            m_vld = '0; m_halt = 1'b0; m_stall = '0; m_flush = '0;
        end else begin
            md  = model_mode();
            ebk = m_vld[3] && wb_ebreak;
            nv  = m_vld;
            if ((md == M_MW || md == M_LU)) m_stall = m_stall + 1;
            if (md == M_RD) m_flush = m_flush + 1;
            case (md)
                M_HALT, M_MW: nv[3] = 1'b0;
                M_RD:         nv = {m_vld[2], 3'b100};
                M_LU:         nv = {m_vld[2], m_vld[1], 1'b0, m_vld[0]};
                default:      nv = {m_vld[2:0], if_inst_vld};
            endcase
            m_vld = nv;
            if (ebk) m_halt = 1'b1;
        end
    end

    always @(negedge clk) begin
        int md;
        if (chk_en) begin
            md = model_mode();
            check("pc_en",        pc_en,        (md == M_RD || md == M_NORM));
            check("pc_sel_redir", pc_sel_redir, (md == M_RD));
            check("hold_id",      hold_id,      (md == M_HALT || md == M_MW || md == M_LU));
            check("hold_ex",      hold_ex,      (md == M_HALT || md == M_MW));
            check("hold_mem",     hold_mem,     (md == M_HALT || md == M_MW));
            check("hold_wb",      hold_wb,      0);
            check("vld_bits",     {vld_wb, vld_mem, vld_ex, vld_id}, m_vld);
            check("halted",       halted,       m_halt);
            check("stall_cnt",    stall_cnt,    m_stall);
            check("flush_cnt",    flush_cnt,    m_flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        if_inst_vld = 1'b1; id_rs1 = '0; id_rs1_en = 1'b0; id_rs2 = '0; id_rs2_en = 1'b0;
        ex_rd = '0; ex_is_load = 1'b0; ex_redirect = 1'b0;
        mem_ls_req = 1'b0; mem_ls_ready = 1'b1; wb_ebreak = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        settle();
        check("rst_vld", {vld_wb, vld_mem, vld_ex, vld_id}, 4'b0000);
        check("rst_pc_en", pc_en, 1);
        check("rst_halted", halted, 0);
        for (int i = 0; i < 4; i++) tick();
        settle();
        check("fill_vld", {vld_wb, vld_mem, vld_ex, vld_id}, 4'b1111);

        // load-use: ld x5 in EX, ID reads x5
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_en = 1'b1;
        settle();
        check("lu_pc_en", pc_en, 0);
        check("lu_hold_id", hold_id, 1);
        tick();
        idle_inputs();
        settle();
        check("lu_bubble_ex", vld_ex, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_resume_pc_en", pc_en, 1);
        tick();

        // x0 load never stalls
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_en = 1'b1; id_rs2_en = 1'b1;
        settle();
        check("x0_pc_en", pc_en, 1);
        check("x0_hold_id", hold_id, 0);
        tick();
        idle_inputs();

        // redirect wins over a simultaneous load-use
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_en = 1'b1; ex_redirect = 1'b1;
        settle();
        check("rd_sel", pc_sel_redir, 1);
        check("rd_pc_en", pc_en, 1);
        tick();
        idle_inputs();
        settle();
        check("rd_squash", {vld_mem, vld_ex, vld_id}, 3'b100);
        check("rd_flush_cnt", flush_cnt, 1);
        check("rd_stall_cnt", stall_cnt, 1);
        for (int i = 0; i < 4; i++) tick();

        // LSU wait three cycles
        mem_ls_req = 1'b1; mem_ls_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lsw_pc_en", pc_en, 0);
            check("lsw_holds", {hold_id, hold_ex, hold_mem}, 3'b111);
            tick();
            check("lsw_vld_wb", vld_wb, 0);
        end
        mem_ls_ready = 1'b1;
        settle();
        check("lsw_release_pc_en", pc_en, 1);
        tick();
        idle_inputs();
        settle();
        check("lsw_stall_cnt", stall_cnt, 4);

        // reset held two cycles while in LS_WAIT
        mem_ls_req = 1'b1; mem_ls_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        idle_inputs();
        settle();
        check("rst2_vld", {vld_wb, vld_mem, vld_ex, vld_id}, 4'b0000);
        check("rst2_pc_en", pc_en, 1);
        check("rst2_cnts", stall_cnt | flush_cnt, 0);
        for (int i = 0; i < 4; i++) tick();

        // ebreak retires -> halt forever, stall counter frozen
        wb_ebreak = 1'b1;
        tick();
        wb_ebreak = 1'b0;
        settle();
        check("halt_halted", halted, 1);
        check("halt_pc_en", pc_en, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check("halt_pc_en_hold", pc_en, 0);
            check("halt_stall_frozen", stall_cnt, 0);
            check("halt_vld_wb", vld_wb, 0);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check("halt_reset_halted", halted, 0);
        check("halt_reset_pc_en", pc_en, 1);
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
